// File: rtl/rubik_pkg.sv
// rubik_pkg: shared types and constants for the cube-net pixel stream.
// Holds the 3-bit colour codes, the RGB565 colour table, the face order
// (U,R,F,D,L,B) and the pixel class used between pipeline stages.
package rubik_pkg;

    localparam int unsigned N_FACELETS = 54;
    localparam int unsigned CODE_W     = 3;
    localparam int unsigned STATE_W    = N_FACELETS * CODE_W;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned PIX_W      = 16;

    // Face order inside the facelet vector
    localparam int unsigned FACE_U = 0;
    localparam int unsigned FACE_R = 1;
    localparam int unsigned FACE_F = 2;
    localparam int unsigned FACE_D = 3;
    localparam int unsigned FACE_L = 4;
    localparam int unsigned FACE_B = 5;

    typedef enum logic [CODE_W-1:0] {
        COL_WHITE   = 3'd0,
        COL_RED     = 3'd1,
        COL_GREEN   = 3'd2,
        COL_YELLOW  = 3'd3,
        COL_ORANGE  = 3'd4,
        COL_BLUE    = 3'd5,
        COL_UNKNOWN = 3'd6,
        COL_NONE    = 3'd7
    } colour_e;

    typedef logic [N_FACELETS-1:0][CODE_W-1:0] facelets_t;

    typedef enum logic [1:0] {
        PIX_BG      = 2'd0,
        PIX_GAP     = 2'd1,
        PIX_STICKER = 2'd2,
        PIX_CURSOR  = 2'd3
    } pix_class_e;

    localparam logic [PIX_W-1:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [PIX_W-1:0] RGB_RED     = 16'hF800;
    localparam logic [PIX_W-1:0] RGB_GREEN   = 16'h07E0;
    localparam logic [PIX_W-1:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [PIX_W-1:0] RGB_ORANGE  = 16'hFD20;
    localparam logic [PIX_W-1:0] RGB_BLUE    = 16'h001F;
    localparam logic [PIX_W-1:0] RGB_UNKNOWN = 16'h8410;
    localparam logic [PIX_W-1:0] RGB_NONE    = 16'h0000;
    localparam logic [PIX_W-1:0] RGB_BG      = 16'h0000;
    localparam logic [PIX_W-1:0] RGB_GAP     = 16'h2104;
    localparam logic [PIX_W-1:0] RGB_CURSOR  = 16'hF81F;

    // Counter width for a modulus n (at least one bit)
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Colour code to RGB565
    function automatic logic [PIX_W-1:0] code_to_rgb(input colour_e c);
        case (c)
            COL_WHITE:   return RGB_WHITE;
            COL_RED:     return RGB_RED;
            COL_GREEN:   return RGB_GREEN;
            COL_YELLOW:  return RGB_YELLOW;
            COL_ORANGE:  return RGB_ORANGE;
            COL_BLUE:    return RGB_BLUE;
            COL_UNKNOWN: return RGB_UNKNOWN;
            default:     return RGB_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rubik_net_counter.sv
// rubik_net_counter: raster position counters for the cube net.
// Ports: clk/rst_n (async active-low), adv (one-cycle advance request);
// outputs fr/fc (face row/col), sr/sc (sticker row/col), sx/sy (pixel within
// sticker pitch), in_net_c (current line inside the net band), wrap_c
// (this advance wraps the frame), frame_start (registered wrap pulse).
module rubik_net_counter
    import rubik_pkg::*;
#(
    parameter int unsigned H_RES      = 240,
    parameter int unsigned V_RES      = 320,
    parameter int unsigned STICKER_PX = 18,
    parameter int unsigned GAP_PX     = 2,
    parameter int unsigned Y_OFF      = 70
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       adv,
    output logic [1:0]                                 fr,
    output logic [1:0]                                 fc,
    output logic [1:0]                                 sr,
    output logic [1:0]                                 sc,
    output logic [cnt_w(STICKER_PX+GAP_PX)-1:0]        sx,
    output logic [cnt_w(STICKER_PX+GAP_PX)-1:0]        sy,
    output logic                                       in_net_c,
    output logic                                       wrap_c,
    output logic                                       frame_start
);

    localparam int unsigned PITCH   = STICKER_PX + GAP_PX;
    localparam int unsigned SUB_W   = cnt_w(PITCH);
    localparam int unsigned X_W     = cnt_w(H_RES);
    localparam int unsigned Y_W     = cnt_w(V_RES);
    localparam int unsigned NET_END = Y_OFF + 9 * PITCH;

    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_RES - 1);
    localparam logic [Y_W-1:0]   Y_OFF_L  = Y_W'(Y_OFF);
    localparam logic [Y_W:0]     NET_END_L = (Y_W+1)'(NET_END);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PITCH - 1);

    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [SUB_W-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [1:0]       sc_q, sc_d, fc_q, fc_d, sr_q, sr_d, fr_q, fr_d;
    logic             frame_start_q, frame_start_d;

    // Cascaded raster counters; y-side sub-counters stay at 0 above the net
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        sc_d          = sc_q;
        fc_d          = fc_q;
        sr_d          = sr_q;
        fr_d          = fr_q;
        frame_start_d = 1'b0;
        wrap_c        = adv && (x_q == X_LAST) && (y_q == Y_LAST);
        in_net_c      = (y_q >= Y_OFF_L) && ({1'b0, y_q} < NET_END_L);

        if (adv) begin
            if (x_q == X_LAST) begin
                x_d  = '0;
                sx_d = '0;
                sc_d = '0;
                fc_d = '0;
                if (y_q == Y_LAST) begin
                    y_d           = '0;
                    sy_d          = '0;
                    sr_d          = '0;
                    fr_d          = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + Y_W'(1);
                    if (y_q >= Y_OFF_L) begin
                        if (sy_q == SUB_LAST) begin
                            sy_d = '0;
                            if (sr_q == 2'd2) begin
                                sr_d = '0;
                                fr_d = (fr_q == 2'd2) ? 2'd0 : fr_q + 2'd1;
                            end else begin
                                sr_d = sr_q + 2'd1;
                            end
                        end else begin
                            sy_d = sy_q + SUB_W'(1);
                        end
                    end
                end
            end else begin
                x_d = x_q + X_W'(1);
                if (sx_q == SUB_LAST) begin
                    sx_d = '0;
                    if (sc_q == 2'd2) begin
                        sc_d = '0;
                        fc_d = fc_q + 2'd1;
                    end else begin
                        sc_d = sc_q + 2'd1;
                    end
                end else begin
                    sx_d = sx_q + SUB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            sc_q          <= '0;
            fc_q          <= '0;
            sr_q          <= '0;
            fr_q          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            sc_q          <= sc_d;
            fc_q          <= fc_d;
            sr_q          <= sr_d;
            fr_q          <= fr_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fr          = fr_q;
    assign fc          = fc_q;
    assign sr          = sr_q;
    assign sc          = sc_q;
    assign sx          = sx_q;
    assign sy          = sy_q;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/rubik_pixel_stream.sv
// rubik_pixel_stream: RGB565 pixel source drawing the cube state as a net.
// Ports: i_clk_100MHz, i_rst_n (async active-low), i_pix_adv (advance level),
// i_facelets (54 x 3-bit codes), i_load (capture pulse), i_cursor (highlight
// index), o_pixel (RGB565), o_frame_start (pulse on wrap to (0,0)).
// Optional: define RUBIK_CURSOR_EN to draw a magenta border on facelet i_cursor.
module rubik_pixel_stream
    import rubik_pkg::*;
#(
    parameter int unsigned H_RES      = 240,
    parameter int unsigned V_RES      = 320,
    parameter int unsigned STICKER_PX = 18,
    parameter int unsigned GAP_PX     = 2,
    parameter int unsigned Y_OFF      = 70
) (
    input  logic               i_clk_100MHz,
    input  logic               i_rst_n,
    input  logic               i_pix_adv,
    input  logic [STATE_W-1:0] i_facelets,
    input  logic               i_load,
    input  logic [IDX_W-1:0]   i_cursor,
    output logic [PIX_W-1:0]   o_pixel,
    output logic               o_frame_start
);

    localparam int unsigned SUB_W = cnt_w(STICKER_PX + GAP_PX);
    localparam logic [SUB_W-1:0] STK_L      = SUB_W'(STICKER_PX);

    logic             pix_adv_q;
    logic             adv_c;
    logic [1:0]       fr, fc, sr, sc;
    logic [SUB_W-1:0] sx, sy;
    logic             in_net_c, wrap_c;

    facelets_t        pending_q, pending_d, shadow_q, shadow_d;
    logic             pending_valid_q, pending_valid_d;

    logic             face_ok_c;
    logic [IDX_W-1:0] base_c, idx_c;
    pix_class_e       pix_class_q, pix_class_d;
    colour_e          code_q, code_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;

    assign adv_c = i_pix_adv && !pix_adv_q;

    rubik_net_counter #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .STICKER_PX (STICKER_PX),
        .GAP_PX     (GAP_PX),
        .Y_OFF      (Y_OFF)
    ) u_counter (
        .clk         (i_clk_100MHz),
        .rst_n       (i_rst_n),
        .adv         (adv_c),
        .fr          (fr),
        .fc          (fc),
        .sr          (sr),
        .sc          (sc),
        .sx          (sx),
        .sy          (sy),
        .in_net_c    (in_net_c),
        .wrap_c      (wrap_c),
        .frame_start (o_frame_start)
    );

    // Pending/shadow: the display copy only changes on the frame wrap
    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        shadow_d        = shadow_q;
        if (wrap_c) begin
            if (i_load) begin
                shadow_d  = i_facelets;
                pending_d = i_facelets;
            end else if (pending_valid_q) begin
                shadow_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (i_load) begin
            pending_d       = i_facelets;
            pending_valid_d = 1'b1;
        end
    end

    // Face map and facelet index (sr*3 built as 2*sr + sr)
    always_comb begin
        face_ok_c = 1'b1;
        base_c    = '0;
        case ({fr, fc})
            4'b00_01: base_c = IDX_W'(FACE_U * 9);
            4'b01_00: base_c = IDX_W'(FACE_L * 9);
            4'b01_01: base_c = IDX_W'(FACE_F * 9);
            4'b01_10: base_c = IDX_W'(FACE_R * 9);
            4'b01_11: base_c = IDX_W'(FACE_B * 9);
            4'b10_01: base_c = IDX_W'(FACE_D * 9);
            default:  face_ok_c = 1'b0;
        endcase
        idx_c = base_c + IDX_W'({sr, 1'b0}) + IDX_W'(sr) + IDX_W'(sc);
    end

`ifdef RUBIK_CURSOR_EN
    logic border_c;
    assign border_c = (sx == '0) || (sx == STK_L - SUB_W'(1)) ||
                      (sy == '0) || (sy == STK_L - SUB_W'(1));
`else
    logic unused_cursor;
    assign unused_cursor = ^i_cursor;
`endif

    // Pixel classification, registered with the colour code
    always_comb begin
        pix_class_d = PIX_BG;
        code_d      = COL_NONE;
        if (in_net_c && face_ok_c) begin
            if ((sx >= STK_L) || (sy >= STK_L)) begin
                pix_class_d = PIX_GAP;
            end else begin
                pix_class_d = PIX_STICKER;
                code_d      = colour_e'(shadow_q[idx_c]);
`ifdef RUBIK_CURSOR_EN
                if (border_c && (i_cursor == idx_c) &&
                    (i_cursor < IDX_W'(N_FACELETS))) begin
                    pix_class_d = PIX_CURSOR;
                end
`endif
            end
        end
    end

    // Colour lookup into the output register
    always_comb begin
        pixel_d = RGB_BG;
        case (pix_class_q)
            PIX_BG:     pixel_d = RGB_BG;
            PIX_GAP:    pixel_d = RGB_GAP;
            PIX_CURSOR: pixel_d = RGB_CURSOR;
            default:    pixel_d = code_to_rgb(code_q);
        endcase
    end

    always_ff @(posedge i_clk_100MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pix_adv_q       <= 1'b0;
            pending_q       <= '1;
            pending_valid_q <= 1'b0;
            shadow_q        <= '1;
            pix_class_q     <= PIX_BG;
            code_q          <= COL_NONE;
            pixel_q         <= RGB_BG;
        end else begin
            pix_adv_q       <= i_pix_adv;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            shadow_q        <= shadow_d;
            pix_class_q     <= pix_class_d;
            code_q          <= code_d;
            pixel_q         <= pixel_d;
        end
    end

    assign o_pixel = pixel_q;

endmodule

// File: tb/tb_rubik_pixel_stream.sv
// Bench for rubik_pixel_stream on a reduced geometry so whole frames stay short:
// sticker 3 px + gap 1 px (pitch 4, face 12 px), 48x46 panel, net on lines 8..43.
// Pixel (x,y): fc = x/12, sc = (x%12)/4, sx = x%4; net lines likewise from y-8.
module tb_rubik_pixel_stream;
    import rubik_pkg::*;

    localparam int unsigned H  = 48;
    localparam int unsigned V  = 46;
    localparam int unsigned S  = 3;
    localparam int unsigned G  = 1;
    localparam int unsigned YO = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               pix_adv;
    logic [STATE_W-1:0] facelets;
    logic               load;
    logic [IDX_W-1:0]   cursor;
    logic [PIX_W-1:0]   pixel;
    logic               frame_start;

    int n_checks = 0;
    int n_pass   = 0;
    int fs_count = 0;
    int bx = 0;
    int by = 0;

    always #5 clk = ~clk;

    rubik_pixel_stream #(
        .H_RES(H), .V_RES(V), .STICKER_PX(S), .GAP_PX(G), .Y_OFF(YO)
    ) dut (
        .i_clk_100MHz  (clk),
        .i_rst_n       (rst_n),
        .i_pix_adv     (pix_adv),
        .i_facelets    (facelets),
        .i_load        (load),
        .i_cursor      (cursor),
        .o_pixel       (pixel),
        .o_frame_start (frame_start)
    );

    always @(negedge clk) if (frame_start) fs_count++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [STATE_W-1:0] set_fl(input logic [STATE_W-1:0] base,
                                                   input int k, input logic [2:0] c);
        logic [STATE_W-1:0] r;
        r = base;
        r[3*k +: 3] = c;
        return r;
    endfunction

    // One advance, 4 cycles long; returns with o_pixel showing the new position
    task automatic adv_step(input bit with_load, input logic [STATE_W-1:0] f);
        @(negedge clk);
        pix_adv = 1'b1;
        if (with_load) begin
            facelets = f;
            load     = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        pix_adv = 1'b0;
        @(negedge clk);
        bx++;
        if (bx == H) begin
            bx = 0;
            by++;
            if (by == V) by = 0;
        end
    endtask

    task automatic load_now(input logic [STATE_W-1:0] f);
        @(negedge clk);
        facelets = f;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic goto_pos(input int tx, input int ty);
        for (int i = 0; i < int'(H * V) && !(bx == tx && by == ty); i++)
            adv_step(1'b0, '0);
    endtask

    task automatic goto_wrap();
        adv_step(1'b0, '0);
        goto_pos(0, 0);
    endtask

    task automatic pix_at(input string tag, input int tx, input int ty, input logic [15:0] exp);
        goto_pos(tx, ty);
        check_eq(tag, 32'(pixel), 32'(exp));
    endtask

    logic [15:0] exp_cur4;
    logic [STATE_W-1:0] f18, h;

    initial begin
`ifdef RUBIK_CURSOR_EN
        exp_cur4 = 16'hF81F;
`else
        exp_cur4 = 16'hFFFF;
`endif
        rst_n = 1'b0; pix_adv = 1'b0; load = 1'b0; facelets = '0; cursor = 6'd60;
        repeat (3) @(negedge clk);
        check_eq("rst_pixel", 32'(pixel), 32'h0);
        check_eq("rst_frame_start", 32'(frame_start), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("pix00_after_rst", 32'(pixel), 32'h0);

        // Frame 0: reset shadow is all code 7; load all-white pending
        load_now('0);
        pix_at("u0_before_wrap", 12, 8, 16'h0000);
        pix_at("gap_frame0", 15, 8, 16'h2104);
        goto_wrap();
        check_eq("fs_count_1", 32'(fs_count), 32'd1);
        check_eq("pix00_frame1", 32'(pixel), 32'h0);
        pix_at("bg_off_map", 0, 8, 16'h0000);
        pix_at("u0_white", 12, 8, 16'hFFFF);
        pix_at("u0_gap", 15, 8, 16'h2104);

        // Frame 1: F facelet 18 to red, held until the wrap
        f18 = set_fl('0, 18, 3'd1);
        load_now(f18);
        pix_at("f18_old", 12, 20, 16'hFFFF);
        goto_wrap();
        check_eq("fs_count_2", 32'(fs_count), 32'd2);

        // Frame 2: new F colour plus cursor probes
        cursor = 6'd4;
        pix_at("cursor_u4_border", 16, 12, exp_cur4);
        pix_at("cursor_u4_centre", 17, 13, 16'hFFFF);
        pix_at("f18_red", 12, 20, 16'hF800);
        pix_at("f19_white", 16, 20, 16'hFFFF);
        cursor = 6'd53;
`ifdef RUBIK_CURSOR_EN
        pix_at("cursor_b53_border", 44, 28, 16'hF81F);
`else
        pix_at("cursor_b53_border", 44, 28, 16'hFFFF);
`endif
        cursor = 6'd54;
        pix_at("cursor_54_none", 46, 30, 16'hFFFF);
        cursor = 6'd60;

        // Pending yellow is superseded by a load on the wrap cycle itself
        load_now(set_fl(f18, 0, 3'd3));
        h = set_fl(set_fl(f18, 0, 3'd5), 27, 3'd6);
        goto_pos(H - 1, V - 1);
        adv_step(1'b1, h);
        check_eq("fs_count_3", 32'(fs_count), 32'd3);
        check_eq("pix00_frame3", 32'(pixel), 32'h0);
        pix_at("bg_above_net", 0, 2, 16'h0000);
        pix_at("u0_blue_wrapload", 12, 8, 16'h001F);
        pix_at("f18_kept", 12, 20, 16'hF800);
        pix_at("d27_unknown", 12, 32, 16'h8410);
        pix_at("last_net_line_gap", 12, 43, 16'h2104);
        pix_at("below_net_bg", 12, 44, 16'h0000);
        pix_at("bottom_bg", 40, 45, 16'h0000);

        // Two loads in one frame: the later one wins
        load_now(set_fl(h, 0, 3'd3));
        load_now(set_fl(h, 0, 3'd4));
        goto_wrap();
        check_eq("fs_count_4", 32'(fs_count), 32'd4);
        pix_at("u0_orange_last", 12, 8, 16'hFD20);
        pix_at("pre_reset_f18", 12, 20, 16'hF800);

        // Reset mid-frame
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_pixel", 32'(pixel), 32'h0);
        check_eq("midreset_fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bx = 0;
        by = 0;
        adv_step(1'b0, '0);
        check_eq("post_reset_pix10", 32'(pixel), 32'h0);
        pix_at("post_reset_u0_black", 12, 8, 16'h0000);
        pix_at("post_reset_gap", 15, 8, 16'h2104);
        check_eq("fs_count_no_reset_pulse", 32'(fs_count), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
